// File: rtl/mini_unpack_fsm.sv
// Word-to-byte unpacker: copies N_WORDS 16-bit words from a word RAM into a byte RAM, low byte first.
// Optional XOR checksum of the written bytes when MINI_UNPACK_XSUM_EN is defined.
module mini_unpack_fsm #(
  parameter int N_WORDS = 2,
  parameter int WA_W    = 1,
  parameter int BA_W    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [WA_W-1:0] word_rd_addr,
  input  logic [15:0]     word_rd_data,
  output logic            byte_we,
  output logic [BA_W-1:0] byte_addr_wr,
  output logic [7:0]      byte_data_wr,
  output logic            busy,
  output logic            done,
  output logic [7:0]      xsum,
  output logic [2:0]      dbg_state
);

  // No handshake: start is a level sampled only in IDLE; busy/done are status only.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WR_LO = 3'd2,
    S_WR_HI = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [WA_W-1:0] LAST_WORD = WA_W'(N_WORDS - 1);

  state_t          r_state;
  logic [WA_W-1:0] r_cnt;
  logic [15:0]     r_buf;

  logic            w_we;
  logic [BA_W-1:0] w_baddr;
  logic [7:0]      w_bdata;
  logic [WA_W-1:0] w_waddr;
  logic            w_busy;
  logic            w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_READ;
            r_cnt   <= '0;
          end
        end
        S_READ: begin
          r_buf   <= word_rd_data;
          r_state <= S_WR_LO;
        end
        S_WR_LO: r_state <= S_WR_HI;
        S_WR_HI: begin
          // Terminal check precedes the increment, so the counter never wraps.
          if (r_cnt == LAST_WORD) begin
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_READ;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode: every output is a function of registered state only.
  always_comb begin
    w_we    = 1'b0;
    w_baddr = '0;
    w_bdata = '0;
    w_waddr = '0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_READ: begin
        w_busy  = 1'b1;
        w_waddr = r_cnt;
      end
      S_WR_LO: begin
        w_busy  = 1'b1;
        w_we    = 1'b1;
        w_baddr = BA_W'({r_cnt, 1'b0});
        w_bdata = r_buf[7:0];
      end
      S_WR_HI: begin
        w_busy  = 1'b1;
        w_we    = 1'b1;
        w_baddr = BA_W'({r_cnt, 1'b1});
        w_bdata = r_buf[15:8];
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  assign word_rd_addr = w_waddr;
  assign byte_we      = w_we;
  assign byte_addr_wr = w_baddr;
  assign byte_data_wr = w_bdata;
  assign busy         = w_busy;
  assign done         = w_done;
  assign dbg_state    = r_state;

`ifdef MINI_UNPACK_XSUM_EN
  logic [7:0] r_xsum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xsum <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_xsum <= '0;
    end else if (w_we) begin
      r_xsum <= r_xsum ^ w_bdata;
    end
  end

  assign xsum = r_xsum;
`else
  assign xsum = 8'h00;
`endif

endmodule
